// File: rtl/uart_port_pkg.sv
// Shared state encodings and defaults for the uart_port serial block.
package uart_port_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 208;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_port_byte_fifo.sv
// Byte-wide FIFO used as both the transmit queue and the receive queue.
// Head is read combinationally from storage; pointers carry one extra wrap bit.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_port.sv
// 8N1 UART with queued transmit and receive paths.
// Receive samples mid-bit after a 2-flop synchronizer; bad stop bits are discarded.
module uart_port
  import uart_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int TX_DEPTH     = 4,
  parameter int RX_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       wr,
  input  logic [7:0] tx_data,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_full,
  output logic       rx_overrun,
  input  logic       uart_rx,
  output logic       uart_tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  // ---------------- transmit path ----------------
  tx_state_t         tx_state;
  tx_state_t         tx_next;
  logic [BAUD_W-1:0] tx_baud;
  logic [2:0]        tx_bit_cnt;
  logic [7:0]        tx_shift;
  logic [7:0]        tx_head;
  logic              tx_empty;
  logic              tx_pop;
  logic              tx_tick;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .resetq (resetq),
    .push   (wr),
    .pop    (tx_pop),
    .din    (tx_data),
    .head   (tx_head),
    .full   (tx_full),
    .empty  (tx_empty)
  );

  assign tx_tick = (tx_baud == BIT_LAST);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) tx_state <= TX_IDLE;
    else         tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (!tx_empty) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit_cnt == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_pop  = 1'b0;
    uart_tx = 1'b1;
    unique case (tx_state)
      TX_IDLE:  tx_pop  = !tx_empty;
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = tx_shift[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  // Baud counter restarts at each bit boundary and stays parked while idle.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_baud    <= '0;
      tx_bit_cnt <= '0;
      tx_shift   <= '0;
    end else begin
      if (tx_state == TX_IDLE || tx_tick) tx_baud <= '0;
      else                                tx_baud <= tx_baud + BAUD_ONE;

      if (tx_state != TX_DATA) tx_bit_cnt <= '0;
      else if (tx_tick)        tx_bit_cnt <= tx_bit_cnt + 3'd1;

      if (tx_pop)                            tx_shift <= tx_head;
      else if (tx_state == TX_DATA && tx_tick) tx_shift <= {1'b0, tx_shift[7:1]};
    end
  end

  // ---------------- receive path ----------------
  rx_state_t         rx_state;
  rx_state_t         rx_next;
  logic [1:0]        rx_sync;
  logic              rx_s;
  logic              rx_prev;
  logic [BAUD_W-1:0] rx_baud;
  logic [2:0]        rx_bit_cnt;
  logic [7:0]        rx_shift;
  logic              rx_tick;
  logic              rx_push;
  logic              rx_full;
  logic              rx_empty;
  logic              rx_drop;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk    (clk),
    .resetq (resetq),
    .push   (rx_push),
    .pop    (rd),
    .din    (rx_shift),
    .head   (rx_data),
    .full   (rx_full),
    .empty  (rx_empty)
  );

  assign rx_valid = !rx_empty;
  assign rx_s     = rx_sync[1];
  assign rx_tick  = (rx_state == RX_START) ? (rx_baud == HALF_LAST) : (rx_baud == BIT_LAST);
  assign rx_drop  = rx_push && rx_full && !rd;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) rx_state <= RX_IDLE;
    else         rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:      if (rx_prev && !rx_s) rx_next = RX_START;
      RX_START:     if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_tick && rx_bit_cnt == 3'd7) rx_next = RX_STOP;
      RX_STOP:      if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      RX_WAIT_HIGH: if (rx_s) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push = 1'b0;
    unique case (rx_state)
      RX_STOP: rx_push = rx_tick && rx_s;
      default: rx_push = 1'b0;
    endcase
  end

  // The first tick after a falling edge lands mid start bit; later ticks are one bit apart.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_baud    <= '0;
      rx_bit_cnt <= '0;
      rx_shift   <= '0;
    end else begin
      if (rx_state == RX_IDLE || rx_state == RX_WAIT_HIGH || rx_tick) rx_baud <= '0;
      else                                                            rx_baud <= rx_baud + BAUD_ONE;

      if (rx_state != RX_DATA) rx_bit_cnt <= '0;
      else if (rx_tick)        rx_bit_cnt <= rx_bit_cnt + 3'd1;

      if (rx_state == RX_DATA && rx_tick) rx_shift <= {rx_s, rx_shift[7:1]};
    end
  end

  // A drop in the same cycle as a clearing read wins, so no overrun is ever lost.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)               rx_overrun <= 1'b0;
    else if (rx_drop)          rx_overrun <= 1'b1;
    else if (rd && rx_valid)   rx_overrun <= 1'b0;
  end

endmodule

// File: doc/uart_port.md
UART_PORT -- requirements
Module: uart_port

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 208: clk cycles per serial bit, minimum 4.
REQ-002 SHALL have parameter TX_DEPTH, default 4: TX FIFO entries, power of two.
REQ-003 SHALL have parameter RX_DEPTH, default 8: RX FIFO entries, power of two.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 resetq  input  1  asynchronous, active-low reset.
REQ-006 wr  input  1  push tx_data into TX FIFO this cycle.
REQ-007 tx_data  input  8  byte to transmit.
REQ-008 rd  input  1  pop RX FIFO head this cycle.
REQ-009 rx_data  output  8  RX FIFO head byte; valid while rx_valid=1.
REQ-010 rx_valid  output  1  RX FIFO non-empty.
REQ-011 tx_full  output  1  TX FIFO full.
REQ-012 rx_overrun  output  1  sticky: a received byte was dropped.
REQ-013 uart_rx  input  1  asynchronous serial line in.
REQ-014 uart_tx  output  1  serial line out, idle high.

Function
REQ-015 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit exactly CLKS_PER_BIT cycles.
REQ-016 wr with TX FIFO not full SHALL enqueue tx_data; wr while full SHALL be ignored, FIFO contents unchanged.
REQ-017 TX FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START when TX FIFO non-empty (byte popped on that transition), START->DATA after one bit time, DATA->STOP after 8 bit times, STOP->IDLE after one bit time.
REQ-018 First start-bit cycle SHALL drive uart_tx low 1 cycle after the wr that fills an empty FIFO while the FSM is IDLE.
REQ-019 Back-to-back frames: STOP->IDLE->START SHALL insert exactly one idle cycle; no other gap.
REQ-020 uart_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-021 RX FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-022 IDLE->START on synchronized high-to-low transition; at CLKS_PER_BIT/2 (integer division) cycles later line sampled: low -> DATA, high -> IDLE (glitch rejected).
REQ-023 DATA SHALL sample 8 bits at successive CLKS_PER_BIT intervals from mid-start, LSB first, then enter STOP.
REQ-024 STOP sample high SHALL push the byte to the RX FIFO and return to IDLE; sample low SHALL discard the byte and enter WAIT_HIGH, leaving WAIT_HIGH to IDLE when the line reads high.
REQ-025 Push to a full RX FIFO without simultaneous rd SHALL drop the byte and set rx_overrun.
REQ-026 rx_overrun SHALL clear only on rd with rx_valid=1 or on reset; set takes priority over clear in the same cycle.
REQ-027 rd while rx_valid=1 SHALL advance the head at the next edge; rx_data presents the head combinationally from storage; rd while empty SHALL be ignored.
REQ-028 Simultaneous push and pop SHALL both succeed in either FIFO, including when full (count unchanged, no drop) and when empty (push only takes effect).
REQ-029 FIFO pointers SHALL wrap modulo depth; occupancy tracked with one extra pointer bit so full and empty are distinguishable.

Reset
REQ-030 resetq low SHALL immediately force uart_tx=1, rx_valid=0, tx_full=0, rx_overrun=0, both FIFOs empty, both FSMs IDLE, bit/baud counters 0, synchronizer flops 1.
REQ-031 Reset mid-frame SHALL abort the frame with no partial byte pushed; after release TX restarts only on new wr.

Structure
REQ-032 Package uart_port_pkg SHALL hold TX/RX state enumerations and the default CLKS_PER_BIT constant.
REQ-033 One sub-module byte_fifo (parameter DEPTH, 8-bit data, push/pop/full/empty/head) SHALL be instantiated for TX and RX.

Verification (bench uses CLKS_PER_BIT=4)
REQ-034 wr 0x55 from idle -> uart_tx low 1 cycle later, then 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles; total frame 40 cycles.
REQ-035 Five wr cycles 0x01..0x05 with TX_DEPTH=4 while the FSM is busy -> tx_full asserted, fifth accepted only if a pop occurred; all accepted bytes sent in order with one idle cycle between frames.
REQ-036 Drive serial frame 0xA3 on uart_rx -> rx_valid=1 with rx_data=0xA3 after stop sample; rd -> rx_valid=0 next cycle.
REQ-037 Start pulse low for 1 cycle only -> no byte pushed, RX returns IDLE; frame with stop bit 0 -> no push, no rx_overrun, and next valid frame 0x3C received correctly.
REQ-038 Send 9 frames with RX_DEPTH=8 and no rd -> 8 bytes held, rx_overrun=1; rd on the ninth push cycle instead -> no drop, rx_overrun stays 0.
REQ-039 Assert resetq low mid-DATA on both TX and RX -> uart_tx=1 same cycle, rx_valid=0, no byte pushed after release.
